// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

   localparam int          XLEN_DEFAULT = 64;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

   typedef enum logic [6:0] {
      OPCODE_LOAD   = 7'h03,
      OPCODE_OP_IMM = 7'h13,
      OPCODE_AUIPC  = 7'h17,
      OPCODE_STORE  = 7'h23,
      OPCODE_OP     = 7'h33,
      OPCODE_LUI    = 7'h37,
      OPCODE_BRANCH = 7'h63,
      OPCODE_JALR   = 7'h67,
      OPCODE_JAL    = 7'h6F
   } opcode_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - wait-state counter bounding instruction-memory latency
module fetch_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] r_count;

   // Expired means this enabled cycle is the last one allowed without an ack
   assign o_expired = i_en && (r_count == CW'(MAX_WAIT - 1));

   // Count enabled cycles; clear has priority so a finished wait restarts at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage owning PC and IR with req/ack memory handshake
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 15
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            fetch_req,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            mem_rd_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_rd_ack,
   input  logic [31:0]     mem_rdata,
   output logic [31:0]     INSTRUCAO,
   output logic [6:0]      op_code,
   output logic [XLEN-1:0] pc_out,
   output logic            instr_valid,
   output logic            fetch_busy,
   output logic            misalign_fault,
   output logic            fetch_timeout
);

   fetch_state_t    r_state;
   logic            r_req;
   logic            r_valid;
   logic            r_timeout;
   logic            r_misalign;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_out;
   logic [31:0]     r_ir;
   logic [XLEN-1:0] r_pend;
   logic            r_pend_vld;

   logic            w_in_req;
   logic            w_ack;
   logic            w_br_ok;
   logic            w_br_bad;
   logic            w_tmr_en;
   logic            w_tmr_clr;
   logic            w_expired;
   logic [XLEN-1:0] w_pc_plus4;

   assign w_in_req   = (r_state == REQ);
   assign w_ack      = w_in_req && mem_rd_ack;
   assign w_br_ok    = branch_taken && (branch_target[1:0] == 2'b00);
   assign w_br_bad   = branch_taken && (branch_target[1:0] != 2'b00);
   assign w_pc_plus4 = r_pc + XLEN'(4);

   // The timer only runs through REQ cycles that see no ack
   assign w_tmr_en  = w_in_req && !mem_rd_ack;
   assign w_tmr_clr = !w_in_req || mem_rd_ack || w_expired;

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   // Fetch FSM with registered request/valid/timeout flags
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (fetch_req) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
               end
            end
            REQ: begin
               if (mem_rd_ack) begin
                  r_state <= VALID;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end else if (w_expired) begin
                  r_state   <= IDLE;
                  r_req     <= 1'b0;
                  r_timeout <= 1'b1;
               end
            end
            VALID: begin
               if (fetch_req) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // PC, IR and pending redirect; a redirect seen during REQ is held until the fetch lands
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pc       <= RESET_PC;
         r_pc_out   <= RESET_PC;
         r_ir       <= NOP_INSTR;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
      end else if (w_ack) begin
         r_ir       <= mem_rdata;
         r_pc_out   <= r_pc;
         r_pend_vld <= 1'b0;
         if (w_br_ok) begin
            r_pc <= branch_target;
         end else if (r_pend_vld) begin
            r_pc <= r_pend;
         end else begin
            r_pc <= w_pc_plus4;
         end
      end else if (w_in_req) begin
         if (w_br_ok) begin
            r_pend     <= branch_target;
            r_pend_vld <= 1'b1;
         end
      end else if (w_br_ok) begin
         r_pc       <= branch_target;
         r_pend_vld <= 1'b0;
      end
   end

   // Sticky flag for redirects to a non-word-aligned target
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_misalign <= 1'b0;
      end else if (w_br_bad) begin
         r_misalign <= 1'b1;
      end
   end

   assign mem_rd_req     = r_req;
   assign fetch_busy     = r_req;
   assign mem_addr       = r_pc;
   assign INSTRUCAO      = r_ir;
   assign op_code        = r_ir[6:0];
   assign pc_out         = r_pc_out;
   assign instr_valid    = r_valid;
   assign misalign_fault = r_misalign;
   assign fetch_timeout  = r_timeout;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for the fetch stage
module tb_instr_fetch_unit;

   localparam int          XLEN     = 64;
   localparam int          MAX_WAIT = 15;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          NONE     = -2;

   typedef struct {
      logic [31:0] word;
      logic [63:0] pc;
   } exp_t;

   logic            CLK;
   logic            RST_N;
   logic            fetch_req;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            mem_rd_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_rd_ack;
   logic [31:0]     mem_rdata;
   logic [31:0]     INSTRUCAO;
   logic [6:0]      op_code;
   logic [XLEN-1:0] pc_out;
   logic            instr_valid;
   logic            fetch_busy;
   logic            misalign_fault;
   logic            fetch_timeout;

   int          n_vec  = 0;
   int          n_miss = 0;
   exp_t        sb_q[$];
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic        m_mis;
   logic        prev_valid;

   instr_fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (64'h0),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .fetch_req      (fetch_req),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .mem_rd_req     (mem_rd_req),
      .mem_addr       (mem_addr),
      .mem_rd_ack     (mem_rd_ack),
      .mem_rdata      (mem_rdata),
      .INSTRUCAO      (INSTRUCAO),
      .op_code        (op_code),
      .pc_out         (pc_out),
      .instr_valid    (instr_valid),
      .fetch_busy     (fetch_busy),
      .misalign_fault (misalign_fault),
      .fetch_timeout  (fetch_timeout)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every rising instr_valid must deliver the oldest expected fetch
   initial prev_valid = 1'b0;
   always @(negedge CLK) begin
      if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_ir", {32'h0, INSTRUCAO}, {32'h0, e.word});
            check_eq("sb_opcode", {57'h0, op_code}, {57'h0, e.word[6:0]});
            check_eq("sb_pc_out", pc_out, e.pc);
         end
      end
      prev_valid = instr_valid;
   end

   // br_at: NONE, -1 (with fetch_req), or REQ-cycle index (== wt means same cycle as ack)
   task automatic do_fetch(input int wt, input logic [31:0] word, input int br_at,
                           input logic [63:0] tgt, input bit dup);
      logic [63:0] addr;
      logic [63:0] nxt;
      exp_t        e;
      int          reqs;
      addr = m_pc;
      nxt  = m_pc + 64'd4;
      if (br_at != NONE) begin
         if (tgt[1:0] != 2'b00) begin
            m_mis = 1'b1;
         end else if (br_at == -1) begin
            addr = tgt;
            nxt  = tgt + 64'd4;
         end else begin
            nxt = tgt;
         end
      end
      e.word = word;
      e.pc   = addr;
      sb_q.push_back(e);
      @(negedge CLK);
      fetch_req = 1'b1;
      if (br_at == -1) begin
         branch_taken  = 1'b1;
         branch_target = tgt;
      end
      @(negedge CLK);
      fetch_req    = 1'b0;
      branch_taken = 1'b0;
      reqs = 0;
      for (int k = 0; k <= wt; k++) begin
         if (mem_rd_req === 1'b1) reqs++;
         check_eq("req_addr", mem_addr, addr);
         check_eq("ir_hold_in_req", {32'h0, INSTRUCAO}, {32'h0, m_ir});
         if (k == br_at) begin
            branch_taken  = 1'b1;
            branch_target = tgt;
         end
         if (dup && k == 0) fetch_req = 1'b1;
         if (k == wt) begin
            mem_rd_ack = 1'b1;
            mem_rdata  = word;
         end
         @(negedge CLK);
         branch_taken = 1'b0;
         fetch_req    = 1'b0;
         mem_rd_ack   = 1'b0;
      end
      check_eq("req_cycles", 64'(reqs), 64'(wt + 1));
      check_eq("valid_after_ack", {63'h0, instr_valid}, 64'd1);
      check_eq("busy_after_ack", {63'h0, fetch_busy}, 64'd0);
      m_ir = word;
      m_pc = nxt;
      @(negedge CLK);
      check_eq("valid_hold", {63'h0, instr_valid}, 64'd1);
      check_eq("misalign", {63'h0, misalign_fault}, {63'h0, m_mis});
   endtask

   task automatic do_branch(input logic [63:0] tgt);
      @(negedge CLK);
      branch_taken  = 1'b1;
      branch_target = tgt;
      @(negedge CLK);
      branch_taken = 1'b0;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      else m_pc = tgt;
      check_eq("branch_misalign", {63'h0, misalign_fault}, {63'h0, m_mis});
   endtask

   task automatic do_timeout();
      int reqs;
      int early;
      @(negedge CLK);
      fetch_req = 1'b1;
      @(negedge CLK);
      fetch_req = 1'b0;
      reqs  = 0;
      early = 0;
      for (int k = 0; k < 40 && mem_rd_req === 1'b1; k++) begin
         reqs++;
         if (fetch_timeout !== 1'b0) early++;
         @(negedge CLK);
      end
      check_eq("to_req_cycles", 64'(reqs), 64'(MAX_WAIT));
      check_eq("to_early_pulse", 64'(early), 64'd0);
      check_eq("to_pulse", {63'h0, fetch_timeout}, 64'd1);
      check_eq("to_valid", {63'h0, instr_valid}, 64'd0);
      check_eq("to_ir", {32'h0, INSTRUCAO}, {32'h0, m_ir});
      @(negedge CLK);
      check_eq("to_pulse_end", {63'h0, fetch_timeout}, 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ir"}, {32'h0, INSTRUCAO}, {32'h0, NOP});
      check_eq({tag, "_pc_out"}, pc_out, 64'h0);
      check_eq({tag, "_flags"},
               {59'h0, instr_valid, fetch_busy, mem_rd_req, misalign_fault, fetch_timeout},
               64'h0);
   endtask

   initial begin
      RST_N         = 1'b0;
      fetch_req     = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      mem_rd_ack    = 1'b0;
      mem_rdata     = '0;
      m_pc          = 64'h0;
      m_ir          = NOP;
      m_mis         = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      check_eq("reset_opcode", {57'h0, op_code}, 64'h13);
      RST_N = 1'b1;

      do_fetch(0, 32'h0050_0093, NONE, 64'h0, 1'b0);
      do_fetch(3, 32'h00A0_0113, NONE, 64'h0, 1'b1);
      do_timeout();
      do_fetch(2, 32'h0000_0063, 1, 64'h100, 1'b0);
      do_fetch(0, 32'h1234_5037, NONE, 64'h0, 1'b0);
      do_branch(64'h102);
      do_fetch(1, 32'h0000_006F, NONE, 64'h0, 1'b0);
      do_fetch(1, 32'h0080_0067, 1, 64'h200, 1'b0);
      do_fetch(0, 32'h0000_0097, -1, 64'h300, 1'b0);

      // Stray ack while holding a valid instruction must not disturb IR
      @(negedge CLK);
      mem_rd_ack = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge CLK);
      mem_rd_ack = 1'b0;
      check_eq("stray_ack_ir", {32'h0, INSTRUCAO}, {32'h0, m_ir});
      check_eq("stray_ack_valid", {63'h0, instr_valid}, 64'd1);

      do_branch(64'hFFFF_FFFF_FFFF_FFFC);
      do_fetch(0, 32'h0000_0033, NONE, 64'h0, 1'b0);
      do_fetch(2, 32'h0000_0023, NONE, 64'h0, 1'b0);

      // Reset mid-fetch, then a late ack once reset is released
      @(negedge CLK);
      fetch_req = 1'b1;
      @(negedge CLK);
      fetch_req = 1'b0;
      check_eq("pre_reset_busy", {63'h0, mem_rd_req}, 64'd1);
      RST_N = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge CLK);
      RST_N      = 1'b1;
      mem_rd_ack = 1'b1;
      mem_rdata  = 32'hBAD0_0BAD;
      @(negedge CLK);
      mem_rd_ack = 1'b0;
      check_reset_outputs("late_ack");
      m_pc  = 64'h0;
      m_ir  = NOP;
      m_mis = 1'b0;
      do_fetch(0, 32'h0010_0013, NONE, 64'h0, 1'b0);

      repeat (2) @(negedge CLK);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
